// File: rtl/enigma_sequencer_if.sv
// -----------------------------------------------------------------------------
// enigma_sequencer_if
// Request/acknowledge bus between the sequencer and the shared encipher
// datapath.
//
// Handshake: the master raises enc_req_out and holds enc_char_out,
// enc_sel_out and enc_pos_out stable until it sees enc_ack_in high on a rising
// clock edge. An ack in the same cycle that req first rises counts. In the
// ack cycle the slave must present enc_result_in, and the master captures it
// on that edge. The master drops req in the next cycle. Any ack while req is
// low is ignored.
//
// Signals:
//   enc_req_out    master->slave  request, held until ack
//   enc_char_out   master->slave  plaintext letter (5 bits)
//   enc_sel_out    master->slave  rotor IDs {left,mid,right} (9 bits)
//   enc_pos_out    master->slave  rotor positions {left,mid,right} (15 bits)
//   enc_ack_in     slave->master  datapath done, result valid this cycle
//   enc_result_in  slave->master  ciphertext letter (5 bits)
// -----------------------------------------------------------------------------
interface enigma_sequencer_if;
  logic        enc_req_out;
  logic [4:0]  enc_char_out;
  logic [8:0]  enc_sel_out;
  logic [14:0] enc_pos_out;
  logic        enc_ack_in;
  logic [4:0]  enc_result_in;

  modport master (
    output enc_req_out, enc_char_out, enc_sel_out, enc_pos_out,
    input  enc_ack_in, enc_result_in
  );

  modport slave (
    input  enc_req_out, enc_char_out, enc_sel_out, enc_pos_out,
    output enc_ack_in, enc_result_in
  );
endinterface

// File: rtl/enigma_sequencer.sv
// -----------------------------------------------------------------------------
// enigma_sequencer
// Central controller between the switch-decode front end and the shared
// encipher datapath. It latches the rotor selection and start positions,
// steps the rotors once per letter (including the middle-rotor double step),
// runs one req/ack transaction per letter and returns the ciphertext. Only one
// letter is in flight at a time.
//
// Optional feature macro: ENC_TIMEOUT_EN adds an ack watchdog. Without it,
// REQ waits indefinitely for ack.
//
// Ports:
//   clk_in            system clock
//   rst_in            asynchronous active-low reset
//   rotor_valid_in    pulse: apply rotor_select_in / rotor_initial_in
//   rotor_select_in   rotor IDs {left[8:6],mid[5:3],right[2:0]}, 0..4 = I..V
//   rotor_initial_in  start positions {left[14:10],mid[9:5],right[4:0]}
//   letter_valid_in   pulse: encipher char_in
//   char_in           plaintext letter 0..25
//   ready_out         high only in IDLE
//   char_valid_out    pulse: char_out valid
//   char_out          ciphertext letter
//   err_out           pulse on any error
//   err_code_out      last error (01 bad rotor, 10 bad char, 11 timeout), held
//   state_dbg_out     current FSM state (IDLE=0, STEP=1, REQ=2, OUT=3)
//   enc               encipher datapath bus (master side)
// -----------------------------------------------------------------------------
module enigma_sequencer #(
  parameter int N_LETTERS      = 26,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rotor_valid_in,
  input  logic [8:0]           rotor_select_in,
  input  logic [14:0]          rotor_initial_in,
  input  logic                 letter_valid_in,
  input  logic [4:0]           char_in,
  output logic                 ready_out,
  output logic                 char_valid_out,
  output logic [4:0]           char_out,
  output logic                 err_out,
  output logic [1:0]           err_code_out,
  output logic [1:0]           state_dbg_out,
  enigma_sequencer_if.master   enc
);

  localparam logic [4:0] LAST = 5'(N_LETTERS - 1);
  localparam logic [4:0] NL   = 5'(N_LETTERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_REQ  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  sel_q;
  logic [14:0] pos_q;
  logic [4:0]  char_q;
  logic [4:0]  result_q;
  logic [1:0]  err_code_q;
  logic        err_q;

  logic cfg_ok, cfg_bad, char_bad, accept, tmo_hit;

  // Notch position of each rotor type (I..V). The default is unreachable
  // because IDs above 4 are rejected at configuration time.
  function automatic logic [4:0] notch_of(input logic [2:0] id);
    case (id)
      3'd0:    notch_of = 5'd16;
      3'd1:    notch_of = 5'd4;
      3'd2:    notch_of = 5'd21;
      3'd3:    notch_of = 5'd9;
      3'd4:    notch_of = 5'd25;
      default: notch_of = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] wrap_inc(input logic [4:0] p);
    wrap_inc = (p == LAST) ? 5'd0 : p + 5'd1;
  endfunction

  // Position fields are 5 bits wide, so a single subtraction brings any
  // out-of-range value (26..31) back into 0..25.
  function automatic logic [4:0] reduce(input logic [4:0] p);
    reduce = (p > LAST) ? p - NL : p;
  endfunction

  // Rotor stepping. Both notch tests look at the pre-step positions; the
  // middle rotor also steps when it sits on its own notch (double step).
  logic [4:0] pos_l, pos_m, pos_r;
  logic       right_at_notch, mid_at_notch;
  logic [14:0] pos_stepped;

  assign pos_l = pos_q[14:10];
  assign pos_m = pos_q[9:5];
  assign pos_r = pos_q[4:0];
  assign right_at_notch = (pos_r == notch_of(sel_q[2:0]));
  assign mid_at_notch   = (pos_m == notch_of(sel_q[5:3]));
  assign pos_stepped = {
    mid_at_notch ? wrap_inc(pos_l) : pos_l,
    (right_at_notch || mid_at_notch) ? wrap_inc(pos_m) : pos_m,
    wrap_inc(pos_r)
  };

  logic bad_id;
  assign bad_id = (rotor_select_in[8:6] > 3'd4) ||
                  (rotor_select_in[5:3] > 3'd4) ||
                  (rotor_select_in[2:0] > 3'd4);

`ifdef ENC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_last;
  // tmo_cnt_q counts REQ cycles already spent; the last allowed cycle is
  // TIMEOUT_CYCLES-1, so err_out appears TIMEOUT_CYCLES cycles after REQ entry.
  assign tmo_last = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // The watchdog limit is accepted but has no effect in this build.
  if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
  end
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d  = state_q;
    cfg_ok   = 1'b0;
    cfg_bad  = 1'b0;
    char_bad = 1'b0;
    accept   = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rotor_valid_in) begin
          if (bad_id) cfg_bad = 1'b1;
          else        cfg_ok  = 1'b1;
        end
        if (letter_valid_in) begin
          if (char_in > LAST) begin
            char_bad = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: state_d = S_REQ;
      S_REQ: begin
        if (enc.enc_ack_in) begin
          state_d = S_OUT;
        end
`ifdef ENC_TIMEOUT_EN
        else if (tmo_last) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Configuration, letter and result registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_q      <= {3'd0, 3'd1, 3'd2};
      pos_q      <= '0;
      char_q     <= '0;
      result_q   <= '0;
      err_code_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= cfg_bad | char_bad | tmo_hit;
      // A bad char reported together with a bad config wins the code.
      if (cfg_bad)  err_code_q <= 2'b01;
      if (char_bad) err_code_q <= 2'b10;
      if (tmo_hit)  err_code_q <= 2'b11;
      if (cfg_ok) begin
        sel_q <= rotor_select_in;
        pos_q <= {reduce(rotor_initial_in[14:10]),
                  reduce(rotor_initial_in[9:5]),
                  reduce(rotor_initial_in[4:0])};
      end
      if (accept) char_q <= char_in;
      if (state_q == S_STEP) pos_q <= pos_stepped;
      if (state_q == S_REQ && enc.enc_ack_in) result_q <= enc.enc_result_in;
    end
  end

`ifdef ENC_TIMEOUT_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                tmo_cnt_q <= '0;
    else if (state_q == S_REQ)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else                        tmo_cnt_q <= '0;
  end
`endif

  // Request and bus contents are decoded from the state register so that an
  // asynchronous reset removes req immediately. The bus fields read as zero
  // outside REQ.
  logic in_req;
  assign in_req = (state_q == S_REQ);

  assign enc.enc_req_out  = in_req;
  assign enc.enc_char_out = in_req ? char_q : 5'd0;
  assign enc.enc_sel_out  = in_req ? sel_q  : 9'd0;
  assign enc.enc_pos_out  = in_req ? pos_q  : 15'd0;

  assign ready_out      = (state_q == S_IDLE);
  assign char_valid_out = (state_q == S_OUT);
  assign char_out       = result_q;
  assign err_out        = err_q;
  assign err_code_out   = err_code_q;
  assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_enigma_sequencer.sv
// -----------------------------------------------------------------------------
// tb_enigma_sequencer
// Directed bench for enigma_sequencer: a table of letter transactions with
// hand-computed rotor positions, followed by hand-written sequences for
// errors, busy behaviour, the ack watchdog and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_enigma_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rotor_valid_in;
  logic [8:0]  rotor_select_in;
  logic [14:0] rotor_initial_in;
  logic        letter_valid_in;
  logic [4:0]  char_in;
  logic        ready_out;
  logic        char_valid_out;
  logic [4:0]  char_out;
  logic        err_out;
  logic [1:0]  err_code_out;
  logic [1:0]  state_dbg_out;

  enigma_sequencer_if enc_bus();

  enigma_sequencer dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rotor_valid_in   (rotor_valid_in),
    .rotor_select_in  (rotor_select_in),
    .rotor_initial_in (rotor_initial_in),
    .letter_valid_in  (letter_valid_in),
    .char_in          (char_in),
    .ready_out        (ready_out),
    .char_valid_out   (char_valid_out),
    .char_out         (char_out),
    .err_out          (err_out),
    .err_code_out     (err_code_out),
    .state_dbg_out    (state_dbg_out),
    .enc              (enc_bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [8:0] sel3(input int l, input int m, input int r);
    return {3'(l), 3'(m), 3'(r)};
  endfunction

  function automatic logic [14:0] pos3(input int l, input int m, input int r);
    return {5'(l), 5'(m), 5'(r)};
  endfunction

  typedef struct {
    logic        apply_cfg;
    logic        same_cycle;
    logic [8:0]  sel;
    logic [14:0] init;
    logic [4:0]  ch;
    int          ack_delay;
    logic [4:0]  result;
    logic [8:0]  exp_sel;
    logic [14:0] exp_pos;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic cfg, input logic same, input logic [8:0] sel,
                              input logic [14:0] init, input int ch, input int dly,
                              input int res, input logic [8:0] esel, input logic [14:0] epos);
    vec_t v;
    v.apply_cfg  = cfg;
    v.same_cycle = same;
    v.sel        = sel;
    v.init       = init;
    v.ch         = 5'(ch);
    v.ack_delay  = dly;
    v.result     = 5'(res);
    v.exp_sel    = esel;
    v.exp_pos    = epos;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Applies one vector: optional config, letter pulse, checks the N+2 request
  // timing and bus contents, acks after ack_delay cycles, checks the output.
  task automatic run_letter(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    if (v.apply_cfg && !v.same_cycle) begin
      rotor_valid_in   = 1'b1;
      rotor_select_in  = v.sel;
      rotor_initial_in = v.init;
      tick();
      rotor_valid_in   = 1'b0;
      check({t, " cfg err_out"}, 32'(err_out), 32'd0);
    end
    letter_valid_in = 1'b1;
    char_in         = v.ch;
    if (v.apply_cfg && v.same_cycle) begin
      rotor_valid_in   = 1'b1;
      rotor_select_in  = v.sel;
      rotor_initial_in = v.init;
    end
    tick();
    letter_valid_in = 1'b0;
    rotor_valid_in  = 1'b0;
    check({t, " ready N+1"}, 32'(ready_out), 32'd0);
    check({t, " req N+1"}, 32'(enc_bus.enc_req_out), 32'd0);
    tick();
    check({t, " req N+2"}, 32'(enc_bus.enc_req_out), 32'd1);
    check({t, " enc_char"}, 32'(enc_bus.enc_char_out), 32'(v.ch));
    check({t, " enc_sel"}, 32'(enc_bus.enc_sel_out), 32'(v.exp_sel));
    check({t, " enc_pos"}, 32'(enc_bus.enc_pos_out), 32'(v.exp_pos));
    for (int i = 0; i < v.ack_delay; i++) begin
      tick();
      check({t, " req held"}, 32'(enc_bus.enc_req_out), 32'd1);
      check({t, " no early valid"}, 32'(char_valid_out), 32'd0);
    end
    enc_bus.enc_ack_in    = 1'b1;
    enc_bus.enc_result_in = v.result;
    tick();
    enc_bus.enc_ack_in    = 1'b0;
    enc_bus.enc_result_in = 5'd31;
    check({t, " char_valid"}, 32'(char_valid_out), 32'd1);
    check({t, " char_out"}, 32'(char_out), 32'(v.result));
    check({t, " req dropped"}, 32'(enc_bus.enc_req_out), 32'd0);
    tick();
    check({t, " valid pulse end"}, 32'(char_valid_out), 32'd0);
    check({t, " ready back"}, 32'(ready_out), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    int n_valid;
    int n_errp;
    rst_in                = 1'b0;
    rotor_valid_in        = 1'b0;
    rotor_select_in       = '0;
    rotor_initial_in      = '0;
    letter_valid_in       = 1'b0;
    char_in               = '0;
    enc_bus.enc_ack_in    = 1'b0;
    enc_bus.enc_result_in = 5'd31;

    //            cfg  same  sel            init               ch  dly res  exp_sel        exp_pos
    vecs[0]  = mk(1'b0, 1'b0, 9'd0,          15'd0,              3,  0,  9, sel3(0,1,2), pos3(0,0,1));
    vecs[1]  = mk(1'b1, 1'b0, sel3(0,1,2),   pos3(0,0,0),        0,  0,  7, sel3(0,1,2), pos3(0,0,1));
    vecs[2]  = mk(1'b1, 1'b0, sel3(0,1,2),   pos3(0,3,21),       4,  2, 11, sel3(0,1,2), pos3(0,4,22));
    vecs[3]  = mk(1'b0, 1'b0, 9'd0,          15'd0,              5,  1, 20, sel3(0,1,2), pos3(1,5,23));
    vecs[4]  = mk(1'b1, 1'b0, sel3(0,1,2),   pos3(0,0,25),      25,  0, 25, sel3(0,1,2), pos3(0,0,0));
    vecs[5]  = mk(1'b1, 1'b0, sel3(4,3,0),   pos3(3,9,16),      12,  3,  1, sel3(4,3,0), pos3(4,10,17));
    vecs[6]  = mk(1'b1, 1'b0, sel3(1,2,3),   pos3(30,27,26),     1,  0,  0, sel3(1,2,3), pos3(4,1,1));
    vecs[7]  = mk(1'b1, 1'b0, sel3(2,4,1),   pos3(25,25,4),     13,  1, 19, sel3(2,4,1), pos3(0,0,5));
    vecs[8]  = mk(1'b1, 1'b1, sel3(0,1,2),   pos3(7,8,9),        2,  0,  3, sel3(0,1,2), pos3(7,8,10));
    vecs[9]  = mk(1'b1, 1'b0, sel3(1,2,3),   pos3(0,0,0),        6,  0,  8, sel3(1,2,3), pos3(0,0,1));
    vecs[10] = mk(1'b0, 1'b0, 9'd0,          15'd0,              7,  0, 10, sel3(1,2,3), pos3(0,0,2));

    // Reset values
    tick();
    tick();
    check("rst ready", 32'(ready_out), 32'd1);
    check("rst req", 32'(enc_bus.enc_req_out), 32'd0);
    check("rst char_valid", 32'(char_valid_out), 32'd0);
    check("rst err", 32'(err_out), 32'd0);
    check("rst err_code", 32'(err_code_out), 32'd0);
    check("rst char_out", 32'(char_out), 32'd0);
    check("rst enc_pos", 32'(enc_bus.enc_pos_out), 32'd0);
    #2 rst_in = 1'b1;
    tick();
    check("post-rst ready", 32'(ready_out), 32'd1);
    check("post-rst state", 32'(state_dbg_out), 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 9; i++) run_letter(i, vecs[i]);

    // Bad rotor ID: old configuration must survive
    run_letter(9, vecs[9]);
    rotor_valid_in   = 1'b1;
    rotor_select_in  = sel3(0,5,0);
    rotor_initial_in = pos3(5,5,5);
    tick();
    rotor_valid_in = 1'b0;
    check("bad id err_out", 32'(err_out), 32'd1);
    check("bad id code", 32'(err_code_out), 32'b01);
    check("bad id ready", 32'(ready_out), 32'd1);
    tick();
    check("bad id pulse end", 32'(err_out), 32'd0);
    check("bad id code held", 32'(err_code_out), 32'b01);
    run_letter(10, vecs[10]);

    // Bad char
    letter_valid_in = 1'b1;
    char_in         = 5'd27;
    tick();
    letter_valid_in = 1'b0;
    check("bad char err_out", 32'(err_out), 32'd1);
    check("bad char code", 32'(err_code_out), 32'b10);
    check("bad char ready", 32'(ready_out), 32'd1);
    tick();
    check("bad char pulse end", 32'(err_out), 32'd0);
    check("bad char no req", 32'(enc_bus.enc_req_out), 32'd0);
    check("bad char still ready", 32'(ready_out), 32'd1);

    // Busy: letter and config pulses during REQ are ignored; ack held 10 cycles
    rotor_valid_in   = 1'b1;
    rotor_select_in  = sel3(0,1,2);
    rotor_initial_in = pos3(0,0,0);
    tick();
    rotor_valid_in  = 1'b0;
    letter_valid_in = 1'b1;
    char_in         = 5'd8;
    tick();
    letter_valid_in = 1'b0;
    tick();
    check("busy req", 32'(enc_bus.enc_req_out), 32'd1);
    letter_valid_in  = 1'b1;
    char_in          = 5'd9;
    rotor_valid_in   = 1'b1;
    rotor_initial_in = pos3(10,10,10);
    tick();
    letter_valid_in = 1'b0;
    rotor_valid_in  = 1'b0;
    check("busy req still", 32'(enc_bus.enc_req_out), 32'd1);
    check("busy enc_char", 32'(enc_bus.enc_char_out), 32'd8);
    n_valid = 0;
    n_errp  = 0;
    enc_bus.enc_ack_in    = 1'b1;
    enc_bus.enc_result_in = 5'd14;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (char_valid_out) n_valid++;
      if (err_out) n_errp++;
    end
    enc_bus.enc_ack_in    = 1'b0;
    enc_bus.enc_result_in = 5'd31;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (char_valid_out) n_valid++;
      if (err_out) n_errp++;
    end
    check("busy one valid", 32'(n_valid), 32'd1);
    check("busy no err", 32'(n_errp), 32'd0);
    check("busy char_out", 32'(char_out), 32'd14);
    check("busy ready", 32'(ready_out), 32'd1);
    check("busy no second req", 32'(enc_bus.enc_req_out), 32'd0);
    // Ignored config must not have changed positions: next step is {0,0,2}
    run_letter(11, mk(1'b0, 1'b0, 9'd0, 15'd0, 1, 0, 2, sel3(0,1,2), pos3(0,0,2)));

`ifdef ENC_TIMEOUT_EN
    // Watchdog: no ack, err_out TIMEOUT_CYCLES cycles after REQ entry
    letter_valid_in = 1'b1;
    char_in         = 5'd0;
    tick();
    letter_valid_in = 1'b0;
    tick();
    check("tmo req", 32'(enc_bus.enc_req_out), 32'd1);
    k = 0;
    while (k < 200 && !err_out) begin
      tick();
      k++;
    end
    check("tmo latency", 32'(k), 32'd64);
    check("tmo code", 32'(err_code_out), 32'b11);
    check("tmo req dropped", 32'(enc_bus.enc_req_out), 32'd0);
    check("tmo ready", 32'(ready_out), 32'd1);
    check("tmo no valid", 32'(char_valid_out), 32'd0);
    // Positions keep the stepped value {0,0,3}; next letter goes to {0,0,4}
    run_letter(12, mk(1'b0, 1'b0, 9'd0, 15'd0, 2, 0, 6, sel3(0,1,2), pos3(0,0,4)));
`endif

    // Async reset while in REQ
    letter_valid_in = 1'b1;
    char_in         = 5'd3;
    tick();
    letter_valid_in = 1'b0;
    tick();
    check("arst req before", 32'(enc_bus.enc_req_out), 32'd1);
`ifndef ENC_TIMEOUT_EN
    k = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!enc_bus.enc_req_out || err_out) k++;
    end
    check("no-watchdog req held", 32'(k), 32'd0);
`endif
    #2 rst_in = 1'b0;
    #1;
    check("arst req drops", 32'(enc_bus.enc_req_out), 32'd0);
    check("arst no valid", 32'(char_valid_out), 32'd0);
    check("arst ready", 32'(ready_out), 32'd1);
    tick();
    #2 rst_in = 1'b1;
    tick();
    check("arst no valid after", 32'(char_valid_out), 32'd0);
    check("arst code cleared", 32'(err_code_out), 32'd0);
    // Defaults restored: IDs {0,1,2}, positions 0
    run_letter(0, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
